uio_bus_arbiter: RTL and testbench
==================================

// Module: uio_bus_arbiter
// PURPOSE
//  Shares the bidirectional uio pad bus (uio_out/uio_oe) of the tt_um_ top level among NREQ
//  internal requesters. Round-robin arbitration, bounded hold time, and an enforced
//  all-inputs turnaround between owners so two drivers never overlap on the pads.
//  Sits between the user datapath blocks and the uio_out/uio_oe top-level ports.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  MAX_HOLD    8   max consecutive GRANT cycles per ownership (1..255)
//  TURNAROUND  1   idle cycles with uio_oe=0 between owners (1..15)
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        async active-low reset
//  ena        in   1        design enable; low forces release, blocks new grants
//  req        in   NREQ     per-requester bus request, level
//  done       in   NREQ     per-requester release strobe, sampled only for owner
//  dout       in   NREQ*8   requester i drive data at [8*i+7:8*i]
//  doe        in   NREQ*8   requester i output enables at [8*i+7:8*i]
//  gnt        out  NREQ     one-hot grant, registered
//  busy       out  1        high in GRANT or TURN
//  timeout    out  1        1-cycle pulse: ownership ended by MAX_HOLD
//  uio_out    out  8        muxed owner data, 0 when no owner
//  uio_oe     out  8        muxed owner enables, 0 when no owner
// BEHAVIOUR
//  - Reset (async assert, sync deassert by clk): state=IDLE, gnt=0, busy=0, timeout=0,
//    uio_out=0, uio_oe=0, hold_cnt=0, turn_cnt=0, last=NREQ-1 (req[0] wins first).
//  - States IDLE, GRANT, TURN. Registered outputs; mux outputs combinational from gnt.
//  - IDLE: if ena && |req, pick first set req scanning last+1, last+2, ... mod NREQ;
//    next cycle: GRANT, gnt=onehot(winner), last=winner, hold_cnt=1. Latency req->gnt = 1.
//  - GRANT: uio_out=dout[owner], uio_oe=doe[owner]. Release when any of:
//    done[owner]=1, req[owner]=0, ena=0, or hold_cnt==MAX_HOLD. Else hold_cnt++.
//    On release: next cycle TURN, gnt=0, turn_cnt=1.
//  - timeout=1 in first TURN cycle only if release cause was hold_cnt==MAX_HOLD and
//    done[owner]=0 and req[owner]=1 and ena=1 (done/req-drop/ena win over timeout).
//  - TURN: gnt=0, uio_oe=0, uio_out=0, busy=1. When turn_cnt==TURNAROUND -> IDLE next cycle;
//    else turn_cnt++. Requests ignored in TURN.
//  - Minimum gap between two grants = TURNAROUND+1 cycles (TURN + IDLE arbitration cycle).
//  - Owner still requesting after timeout re-enters round-robin; others with req win first.
//  - done/req of non-owners in GRANT ignored. doe/dout of non-owners never reach pads.
//  - gnt is one-hot or zero at all times; uio_oe nonzero only while gnt!=0.
//  - ena=0 in IDLE: stay IDLE. ena=0 in TURN: no effect on TURN countdown.
//  - rst_n low mid-GRANT: pads released (uio_oe=0) asynchronously same cycle.
// TESTING
//  T1 reset: rst_n=0 with req=4'b1111 -> gnt=0, uio_oe=0, busy=0; release, 1st grant gnt=4'b0001.
//  T2 single: req[2]=1,doe[2]=8'hF0,dout[2]=8'hA5 at cycle n -> gnt=4'b0100 at n+1,
//     uio_out=8'hA5, uio_oe=8'hF0; done[2] pulse at m -> gnt=0, uio_oe=0 at m+1.
//  T3 round-robin: req=4'b1011 held, done pulsed each grant -> grant order 0,1,3,0,1,3;
//     each gap has exactly TURNAROUND cycles with uio_oe=0 then one IDLE cycle.
//  T4 timeout: req[1]=1 held, no done, MAX_HOLD=8 -> gnt[1] high exactly 8 cycles,
//     timeout=1 for 1 cycle on next; done[1] asserted on 8th cycle -> timeout stays 0.
//  T5 ena: ena=0 during GRANT -> release next cycle, timeout=0; ena=0 with req -> no grant.
//  T6 reset mid-grant: rst_n=0 while gnt=4'b1000 -> uio_oe=0 immediately; after release
//     with req=4'b1000 -> gnt=4'b1000 after one IDLE cycle.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner arbitration for the shared uio pad bus, with a bounded hold time
// and an all-inputs turnaround between owners so two drivers never overlap on the pads.
module uio_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   done,
  input  logic [NREQ*8-1:0] dout,
  input  logic [NREQ*8-1:0] doe,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              timeout,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic              busy_r, busy_s;
  logic              timeout_r, timeout_s;
  logic [7:0]        hold_cnt_r, hold_cnt_s;
  logic [3:0]        turn_cnt_r, turn_cnt_s;
  logic [IDX_W-1:0]  last_r, last_s;
  logic [IDX_W-1:0]  win_s;
  logic [IDX_W-1:0]  idx_s;
  logic              found_s;
  logic              release_s;
  logic              at_max_s;
  logic [7:0]        uio_out_s, uio_oe_s;

  // Round-robin pick: first active request scanning upward from the one after the last owner.
  always_comb begin
    win_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s = IDX_W'((int'(last_r) + k) % NREQ);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Owner release conditions; last_r names the owner while in GRANT.
  always_comb begin
    at_max_s  = (hold_cnt_r == 8'(MAX_HOLD));
    release_s = done[last_r] | ~req[last_r] | ~ena | at_max_s;
  end

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    busy_s     = busy_r;
    timeout_s  = 1'b0;
    hold_cnt_s = hold_cnt_r;
    turn_cnt_s = turn_cnt_r;
    last_s     = last_r;
    case (state_r)
      IDLE: begin
        if (ena && found_s) begin
          state_s    = GRANT;
          gnt_s      = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          last_s     = win_s;
          hold_cnt_s = 8'd1;
          busy_s     = 1'b1;
        end else begin
          gnt_s  = '0;
          busy_s = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_s    = TURN;
          gnt_s      = '0;
          busy_s     = 1'b1;
          turn_cnt_s = 4'd1;
          // Only a pure hold-limit expiry counts as a timeout; voluntary release wins.
          timeout_s  = at_max_s & ~done[last_r] & req[last_r] & ena;
        end else begin
          hold_cnt_s = hold_cnt_r + 8'd1;
          busy_s     = 1'b1;
        end
      end
      TURN: begin
        gnt_s = '0;
        if (turn_cnt_r == 4'(TURNAROUND)) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          turn_cnt_s = turn_cnt_r + 4'd1;
          busy_s     = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gnt_r      <= '0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      hold_cnt_r <= 8'd0;
      turn_cnt_r <= 4'd0;
      last_r     <= IDX_W'(NREQ - 1);
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      busy_r     <= busy_s;
      timeout_r  <= timeout_s;
      hold_cnt_r <= hold_cnt_s;
      turn_cnt_r <= turn_cnt_s;
      last_r     <= last_s;
    end
  end

  // Pad mux driven straight from the registered grant, so reset frees the pads at once.
  always_comb begin
    uio_out_s = 8'h00;
    uio_oe_s  = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      uio_out_s = uio_out_s | (dout[8*i +: 8] & {8{gnt_r[i]}});
      uio_oe_s  = uio_oe_s  | (doe[8*i +: 8]  & {8{gnt_r[i]}});
    end
  end

  assign gnt     = gnt_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;
  assign uio_out = uio_out_s;
  assign uio_oe  = uio_oe_s;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: reset, single owner, round-robin order,
// hold-limit timeout, enable gating and reset during a grant.
module tb_uio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req;
  logic [3:0]  done;
  logic [31:0] dout;
  logic [31:0] doe;
  logic [3:0]  gnt;
  logic        busy;
  logic        timeout;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;

  int n_total = 0;
  int n_pass  = 0;

  uio_bus_arbiter #(.NREQ(4), .MAX_HOLD(8), .TURNAROUND(1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .done(done),
    .dout(dout), .doe(doe), .gnt(gnt), .busy(busy), .timeout(timeout),
    .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; req = 4'b1111; done = 4'b0000;
    dout  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    doe   = {8'h44, 8'h33, 8'h22, 8'h11};
    step(); step();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_total++; if (uio_oe !== 8'h00) $display("FAIL reset_oe: got %h want 00", uio_oe); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (gnt !== 4'b0001) $display("FAIL reset_first_gnt: got %b want 0001", gnt); else n_pass++;
    n_total++; if (uio_out !== 8'hA0 || uio_oe !== 8'h11)
      $display("FAIL reset_first_pads: got %h/%h want a0/11", uio_out, uio_oe); else n_pass++;
    req = 4'b0000;
    step();
    n_total++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL reset_turn: got gnt=%b busy=%b want 0000/1", gnt, busy); else n_pass++;
    step();
    n_total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_single();
    dout[23:16] = 8'hA5; doe[23:16] = 8'hF0;
    req = 4'b0100;
    step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", gnt); else n_pass++;
    n_total++; if (uio_out !== 8'hA5 || uio_oe !== 8'hF0)
      $display("FAIL single_pads: got %h/%h want a5/f0", uio_out, uio_oe); else n_pass++;
    step(); step();
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_hold: got %b want 0100", gnt); else n_pass++;
    done = 4'b0100;
    step();
    done = 4'b0000;
    n_total++; if (gnt !== 4'b0000 || uio_oe !== 8'h00)
      $display("FAIL single_done: got gnt=%b oe=%h want 0000/00", gnt, uio_oe); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL single_timeout: got %b want 0", timeout); else n_pass++;
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
    logic [7:0] exp_out [6] = '{8'hA0, 8'hB1, 8'hD3, 8'hA0, 8'hB1, 8'hD3};
    req = 4'b1011;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      n_total++; if (gnt !== exp_gnt[i] || uio_out !== exp_out[i])
        $display("FAIL rr_grant_%0d: got %b/%h want %b/%h", i, gnt, uio_out, exp_gnt[i], exp_out[i]); else n_pass++;
      done = 4'b1111;
      step();
      done = 4'b0000;
      n_total++; if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b1)
        $display("FAIL rr_turn_%0d: got gnt=%b oe=%h busy=%b want 0000/00/1", i, gnt, uio_oe, busy); else n_pass++;
      step();
      n_total++; if (gnt !== 4'b0000 || uio_oe !== 8'h00 || busy !== 1'b0)
        $display("FAIL rr_idle_%0d: got gnt=%b oe=%h busy=%b want 0000/00/0", i, gnt, uio_oe, busy); else n_pass++;
      step();
    end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_timeout();
    req = 4'b0010;
    step();
    for (int i = 1; i <= 8; i++) begin
      n_total++; if (gnt !== 4'b0010 || timeout !== 1'b0)
        $display("FAIL to_hold_%0d: got gnt=%b timeout=%b want 0010/0", i, gnt, timeout); else n_pass++;
      step();
    end
    n_total++; if (gnt !== 4'b0000 || timeout !== 1'b1)
      $display("FAIL to_expire: got gnt=%b timeout=%b want 0000/1", gnt, timeout); else n_pass++;
    step();
    n_total++; if (timeout !== 1'b0) $display("FAIL to_pulse_width: got %b want 0", timeout); else n_pass++;
    step();
    n_total++; if (gnt !== 4'b0010) $display("FAIL to_reenter: got %b want 0010", gnt); else n_pass++;
    for (int j = 0; j < 7; j++) step();
    n_total++; if (gnt !== 4'b0010) $display("FAIL to_eighth: got %b want 0010", gnt); else n_pass++;
    done = 4'b0010;
    step();
    done = 4'b0000;
    n_total++; if (gnt !== 4'b0000 || timeout !== 1'b0)
      $display("FAIL to_done_wins: got gnt=%b timeout=%b want 0000/0", gnt, timeout); else n_pass++;
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_ena();
    req = 4'b0001;
    step();
    n_total++; if (gnt !== 4'b0001) $display("FAIL ena_gnt: got %b want 0001", gnt); else n_pass++;
    step();
    ena = 1'b0;
    step();
    n_total++; if (gnt !== 4'b0000 || timeout !== 1'b0 || uio_oe !== 8'h00)
      $display("FAIL ena_release: got gnt=%b timeout=%b oe=%h want 0000/0/00", gnt, timeout, uio_oe); else n_pass++;
    step(); step(); step();
    n_total++; if (gnt !== 4'b0000 || busy !== 1'b0)
      $display("FAIL ena_block: got gnt=%b busy=%b want 0000/0", gnt, busy); else n_pass++;
    ena = 1'b1;
    step();
    n_total++; if (gnt !== 4'b0001) $display("FAIL ena_resume: got %b want 0001", gnt); else n_pass++;
    req = 4'b0000;
    step(); step(); step();
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b1000;
    step();
    n_total++; if (gnt !== 4'b1000 || uio_oe !== 8'h44)
      $display("FAIL mid_gnt: got gnt=%b oe=%h want 1000/44", gnt, uio_oe); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (uio_oe !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0)
      $display("FAIL mid_async: got oe=%h gnt=%b busy=%b want 00/0000/0", uio_oe, gnt, busy); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (gnt !== 4'b1000 || uio_out !== 8'hD3)
      $display("FAIL mid_regrant: got gnt=%b out=%h want 1000/d3", gnt, uio_out); else n_pass++;
    req = 4'b0000;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ena();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
